// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one ALU and its B-operand select between two requesters.
//   Requester 0 is the main execute path. Requester 1 is an auxiliary unit.
//   One operation is in flight at a time. The winner's operands are
//   registered on acceptance. The ALU result is captured after one execute
//   cycle and is returned on a valid/ready response channel.
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester request handshake (bit i = requester i)
//   req_a/wd/imm        : per-requester operands (slice i = requester i)
//   req_alu_src/ctrl    : per-requester B select (1 = imm) and opcode
//   rsp_valid/rsp_ready : per-requester response handshake
//   rsp_result/rsp_zero : captured ALU outputs, shared and qualified by rsp_valid
//   alu_a/wd/imm/src/ctrl : registered operands driving the ALU and B mux
//   alu_result/alu_zero : combinational ALU outputs
//   busy                : an operation is executing or awaiting its response
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*WIDTH-1:0]    req_a,
  input  logic [2*WIDTH-1:0]    req_wd,
  input  logic [2*WIDTH-1:0]    req_imm,
  input  logic [1:0]            req_alu_src,
  input  logic [2*CTRL_W-1:0]   req_alu_ctrl,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_zero,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_wd,
  output logic [WIDTH-1:0]      alu_imm,
  output logic                  alu_src,
  output logic [CTRL_W-1:0]     alu_ctrl,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_zero,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_q,  last_d;
  logic [WIDTH-1:0]    a_q,   a_d;
  logic [WIDTH-1:0]    wd_q,  wd_d;
  logic [WIDTH-1:0]    imm_q, imm_d;
  logic                src_q, src_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [WIDTH-1:0]    res_q, res_d;
  logic                zero_q, zero_d;
  logic                win;

  // Winner selection: a lone request wins; on a tie the requester that was
  // not accepted most recently wins.
  always_comb begin
    win = 1'b0;
    case (req_valid)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_q;
      default: win = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    a_d       = a_q;
    wd_d      = wd_q;
    imm_d     = imm_q;
    src_d     = src_q;
    ctrl_d    = ctrl_q;
    res_d     = res_q;
    zero_d    = zero_q;
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      IDLE: begin
        if ((|req_valid) && !rst) begin
          req_ready[win] = 1'b1;
          a_d     = win ? req_a[2*WIDTH-1:WIDTH]   : req_a[WIDTH-1:0];
          wd_d    = win ? req_wd[2*WIDTH-1:WIDTH]  : req_wd[WIDTH-1:0];
          imm_d   = win ? req_imm[2*WIDTH-1:WIDTH] : req_imm[WIDTH-1:0];
          src_d   = req_alu_src[win];
          ctrl_d  = win ? req_alu_ctrl[2*CTRL_W-1:CTRL_W] : req_alu_ctrl[CTRL_W-1:0];
          grant_d = win;
          last_d  = win;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_result;
        zero_d  = alu_zero;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid[grant_q] = 1'b1;
        if (rsp_ready[grant_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      a_q     <= '0;
      wd_q    <= '0;
      imm_q   <= '0;
      src_q   <= 1'b0;
      ctrl_q  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      a_q     <= a_d;
      wd_q    <= wd_d;
      imm_q   <= imm_d;
      src_q   <= src_d;
      ctrl_q  <= ctrl_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_wd     = wd_q;
  assign alu_imm    = imm_q;
  assign alu_src    = src_q;
  assign alu_ctrl   = ctrl_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int W  = 32;
  localparam int CW = 4;
  localparam logic [CW-1:0] OP_ADD = 4'd0;
  localparam logic [CW-1:0] OP_SUB = 4'd1;
  localparam logic [CW-1:0] OP_AND = 4'd2;
  localparam logic [CW-1:0] OP_OR  = 4'd3;
  localparam logic [CW-1:0] OP_XOR = 4'd4;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid, req_ready, req_alu_src, rsp_valid, rsp_ready;
  logic [2*W-1:0]    req_a, req_wd, req_imm;
  logic [2*CW-1:0]   req_alu_ctrl;
  logic [W-1:0]      rsp_result, alu_a, alu_wd, alu_imm, alu_result;
  logic              rsp_zero, alu_src, alu_zero, busy;
  logic [CW-1:0]     alu_ctrl;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(W), .CTRL_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_wd(req_wd), .req_imm(req_imm),
    .req_alu_src(req_alu_src), .req_alu_ctrl(req_alu_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_wd(alu_wd), .alu_imm(alu_imm),
    .alu_src(alu_src), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy)
  );

  function automatic logic [W-1:0] alu_f(input logic [CW-1:0] op,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  // ALU the block drives
  always_comb begin
    alu_result = alu_f(alu_ctrl, alu_a, alu_src ? alu_imm : alu_wd);
    alu_zero   = (alu_result == '0);
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an operation is either absent, executing
  // (age 0) or awaiting its response (age 1).
  bit           m_busy = 0;
  int           m_age  = 0;
  bit           m_owner = 0, m_last = 1;
  logic [W-1:0] m_a = '0, m_wd = '0, m_imm = '0, m_res = '0;
  logic         m_src = 0, m_zero = 0;
  logic [CW-1:0] m_ctrl = '0;

  always @(negedge clk) begin
    logic [1:0] exp_ready, exp_rv;
    int w;
    exp_ready = 2'b00;
    if (!rst && !m_busy && (req_valid != 2'b00))
      exp_ready = (req_valid == 2'b11) ? (m_last ? 2'b01 : 2'b10) : req_valid;
    exp_rv = (m_busy && m_age == 1) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;

    chk("m_req_ready", W'(req_ready), W'(exp_ready));
    chk("m_rsp_valid", W'(rsp_valid), W'(exp_rv));
    chk("m_busy",      W'(busy),      W'(m_busy));
    chk("m_rsp_result", rsp_result,   m_res);
    chk("m_rsp_zero",  W'(rsp_zero),  W'(m_zero));
    chk("m_alu_a",     alu_a,         m_a);
    chk("m_alu_wd",    alu_wd,        m_wd);
    chk("m_alu_imm",   alu_imm,       m_imm);
    chk("m_alu_src",   W'(alu_src),   W'(m_src));
    chk("m_alu_ctrl",  W'(alu_ctrl),  W'(m_ctrl));

    if (rst) begin
      m_busy = 0; m_age = 0; m_owner = 0; m_last = 1;
      m_a = '0; m_wd = '0; m_imm = '0; m_src = 0; m_ctrl = '0;
      m_res = '0; m_zero = 0;
    end else if (!m_busy) begin
      if (exp_ready != 2'b00) begin
        w = exp_ready[1] ? 1 : 0;
        m_a    = req_a[w*W +: W];
        m_wd   = req_wd[w*W +: W];
        m_imm  = req_imm[w*W +: W];
        m_src  = req_alu_src[w];
        m_ctrl = req_alu_ctrl[w*CW +: CW];
        m_busy = 1; m_age = 0; m_owner = exp_ready[1]; m_last = exp_ready[1];
      end
    end else if (m_age == 0) begin
      m_res  = alu_f(m_ctrl, m_a, m_src ? m_imm : m_wd);
      m_zero = (m_res == '0);
      m_age  = 1;
    end else if (rsp_ready[m_owner]) begin
      m_busy = 0;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] wd,
                         input logic [W-1:0] imm, input logic src, input logic [CW-1:0] op);
    req_a[i*W +: W]          = a;
    req_wd[i*W +: W]         = wd;
    req_imm[i*W +: W]        = imm;
    req_alu_src[i]           = src;
    req_alu_ctrl[i*CW +: CW] = op;
  endtask

  // One full operation from a single requester with literal expectations.
  task automatic single_op(input int i, input logic exp_src,
                           input logic [W-1:0] exp_res, input logic exp_zero, input string tag);
    logic [1:0] onehot;
    onehot = (i == 1) ? 2'b10 : 2'b01;
    req_valid = onehot;
    @(negedge clk);
    chk({tag, "_accept_ready"}, W'(req_ready), W'(onehot));
    cyc();
    req_valid = 2'b00;
    @(negedge clk);
    chk({tag, "_exec_src"},  W'(alu_src), W'(exp_src));
    chk({tag, "_exec_busy"}, W'(busy), 1);
    @(negedge clk);
    chk({tag, "_rsp_valid"},  W'(rsp_valid), W'(onehot));
    chk({tag, "_rsp_result"}, rsp_result, exp_res);
    chk({tag, "_rsp_zero"},   W'(rsp_zero), W'(exp_zero));
    cyc();
  endtask

  initial begin
    rst = 1; req_valid = '0; rsp_ready = 2'b11;
    req_a = '0; req_wd = '0; req_imm = '0; req_alu_src = '0; req_alu_ctrl = '0;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_req_ready", W'(req_ready), 0);
    chk("rst_rsp_valid", W'(rsp_valid), 0);
    chk("rst_busy", W'(busy), 0);
    chk("rst_alu_a", alu_a, 0);
    cyc();
    rst = 0;

    set_req(0, 5, 7, 100, 1'b0, OP_ADD);
    single_op(0, 1'b0, 12, 1'b0, "r0_add");

    set_req(1, 5, 3, 100, 1'b1, OP_ADD);
    single_op(1, 1'b1, 105, 1'b0, "r1_imm");

    set_req(0, 9, 9, 1, 1'b0, OP_SUB);
    single_op(0, 1'b0, 0, 1'b1, "sub_zero");

    // Response stall; requester 1 waits behind it; non-granted ready ignored.
    rsp_ready = 2'b00;
    set_req(0, 1, 2, 50, 1'b0, OP_ADD);
    set_req(1, 32'hF0, 32'h3C, 0, 1'b0, OP_XOR);
    req_valid = 2'b01;
    @(negedge clk);
    chk("stall_accept", W'(req_ready), 1);
    cyc();
    req_valid = 2'b10;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("stall_rsp_valid", W'(rsp_valid), 1);
      chk("stall_result", rsp_result, 3);
      chk("stall_busy", W'(busy), 1);
      chk("stall_req_ready", W'(req_ready), 0);
      cyc();
      rsp_ready = (i == 3) ? 2'b10 : 2'b00;
      @(negedge clk);
    end
    chk("stall_still_valid", W'(rsp_valid), 1);
    cyc();
    rsp_ready = 2'b01;
    @(negedge clk);
    chk("stall_last_valid", W'(rsp_valid), 1);
    @(negedge clk);
    chk("release_busy", W'(busy), 0);
    chk("release_next_ready", W'(req_ready), 2);
    cyc();
    req_valid = 2'b00; rsp_ready = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("xor_result", rsp_result, 32'hCC);
    cyc();

    // Reset during EXEC abandons the operation.
    set_req(0, 20, 22, 0, 1'b0, OP_OR);
    req_valid = 2'b01;
    @(negedge clk);
    chk("rstx_accept", W'(req_ready), 1);
    cyc();
    req_valid = 2'b00; rst = 1;
    @(negedge clk);
    chk("rstx_ready", W'(req_ready), 0);
    chk("rstx_no_rsp", W'(rsp_valid), 0);
    cyc();
    rst = 0;
    @(negedge clk);
    chk("rstx_busy", W'(busy), 0);
    chk("rstx_alu_a", alu_a, 0);
    chk("rstx_rsp_valid", W'(rsp_valid), 0);
    chk("rstx_result", rsp_result, 0);
    cyc();
    set_req(1, 4, 0, 6, 1'b1, OP_ADD);
    single_op(1, 1'b1, 10, 1'b0, "post_rst");

    // Both requesters valid from reset: grants alternate starting with 0.
    rst = 1;
    cyc();
    rst = 0;
    set_req(0, 32'h10, 32'h01, 0, 1'b0, OP_AND);
    set_req(1, 32'h7, 0, 32'h8, 1'b1, OP_SUB);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      bit seen;
      seen = 0;
      for (int t = 0; t < 10 && !seen; t++) begin
        @(negedge clk);
        if (req_ready != 2'b00) seen = 1;
      end
      if (!seen) chk("rr_timeout", 0, 1);
      else chk("rr_grant", W'(req_ready), (k % 2 == 1) ? 2 : 1);
      cyc();
    end
    req_valid = 2'b00;
    cyc(); cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
